// File: rtl/fram_burst_master.sv
// rtl/fram_burst_master.sv - FM24CLxx FRAM burst controller driving an I2C master command/data stream
module fram_burst_master #(
    parameter int         ADDR_W         = 11,
    parameter logic [2:0] DEV_SEL        = 3'b000,
    parameter int         MAX_BURST      = 16,
    parameter int         TIMEOUT_CYCLES = 65535,
    localparam int        LEN_W          = $clog2(MAX_BURST)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_read,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [7:0]        wr_tdata,
    input  logic              wr_tvalid,
    output logic              wr_tready,
    output logic [7:0]        rd_tdata,
    output logic              rd_tvalid,
    output logic              rd_tlast,
    input  logic              rd_tready,
    output logic              busy,
    output logic              done,
    output logic              timeout_err,
    output logic [6:0]        s_axis_cmd_address,
    output logic              s_axis_cmd_start,
    output logic              s_axis_cmd_read,
    output logic              s_axis_cmd_write,
    output logic              s_axis_cmd_write_multiple,
    output logic              s_axis_cmd_stop,
    output logic              s_axis_cmd_valid,
    input  logic              s_axis_cmd_ready,
    output logic [7:0]        s_axis_data_tdata,
    output logic              s_axis_data_tvalid,
    output logic              s_axis_data_tlast,
    input  logic              s_axis_data_tready,
    input  logic [7:0]        m_axis_data_tdata,
    input  logic              m_axis_data_tvalid,
    input  logic              m_axis_data_tlast,
    output logic              m_axis_data_tready
);
    typedef enum logic [3:0] {
        S_IDLE, S_W_CMD, S_W_ADDR, S_W_DATA, S_R_CMDW, S_R_ADDR, S_R_CMDR, S_R_WAIT, S_DONE
    } state_t;

    localparam int              WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT_CYCLES > 0) ? WD_W'(TIMEOUT_CYCLES - 1) : '0;

    state_t            state_q, state_d;
    logic              read_q, read_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;

    logic       cmd_v, c_start, c_read, c_write, c_wm, c_stop;
    logic       dat_v, dat_l, wr_rdy, rd_v, rd_l, m_rdy;
    logic [7:0] dat_b, rd_b;
    logic       hs, timeout, last_byte;
    logic [2:0] page;
    // The byte counter already marks the final byte, so the master's tlast is redundant.
    logic       unused_m_tlast;

    assign unused_m_tlast = m_axis_data_tlast;
    assign last_byte      = (idx_q == len_q);
    assign page           = 3'(addr_q >> 8);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            read_q  <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            read_q  <= read_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            wdog_q  <= wdog_d;
        end
    end

    always_comb begin
        state_d = state_q;
        read_d  = read_q;
        addr_d  = addr_q;
        len_d   = len_q;
        idx_d   = idx_q;
        wdog_d  = wdog_q;
        cmd_v   = 1'b0;
        c_start = 1'b0;
        c_read  = 1'b0;
        c_write = 1'b0;
        c_wm    = 1'b0;
        c_stop  = 1'b0;
        dat_v   = 1'b0;
        dat_b   = 8'h00;
        dat_l   = 1'b0;
        wr_rdy  = 1'b0;
        rd_v    = 1'b0;
        rd_b    = 8'h00;
        rd_l    = 1'b0;
        m_rdy   = 1'b0;

        case (state_q)
            S_W_CMD:  begin cmd_v = 1'b1; c_start = 1'b1; c_wm = 1'b1; c_stop = 1'b1; end
            S_W_ADDR: begin dat_v = 1'b1; dat_b = addr_q[7:0]; end
            S_W_DATA: begin
                dat_v  = wr_tvalid;
                dat_b  = wr_tdata;
                dat_l  = last_byte;
                wr_rdy = s_axis_data_tready;
            end
            S_R_CMDW: begin cmd_v = 1'b1; c_start = 1'b1; c_write = 1'b1; end
            S_R_ADDR: begin dat_v = 1'b1; dat_b = addr_q[7:0]; dat_l = 1'b1; end
            S_R_CMDR: begin
                cmd_v   = 1'b1;
                c_start = (idx_q == '0);
                c_read  = 1'b1;
                c_stop  = last_byte;
            end
            S_R_WAIT: begin
                rd_v  = m_axis_data_tvalid;
                rd_b  = m_axis_data_tdata;
                rd_l  = last_byte;
                m_rdy = rd_tready;
            end
            default: ;
        endcase

        hs = ((state_q == S_IDLE) && cmd_valid) || (cmd_v && s_axis_cmd_ready) ||
             (dat_v && s_axis_data_tready) || (rd_v && rd_tready);
        // A handshake in the expiry cycle keeps the burst alive.
        timeout = (TIMEOUT_CYCLES != 0) && (state_q != S_IDLE) && (state_q != S_DONE) &&
                  !hs && (wdog_q == WD_LAST);

        case (state_q)
            S_IDLE: if (cmd_valid) begin
                read_d  = cmd_read;
                addr_d  = cmd_addr;
                len_d   = cmd_len;
                idx_d   = '0;
                state_d = cmd_read ? S_R_CMDW : S_W_CMD;
            end
            S_W_CMD:  if (s_axis_cmd_ready) state_d = S_W_ADDR;
            S_W_ADDR: if (s_axis_data_tready) state_d = S_W_DATA;
            S_W_DATA: if (wr_tvalid && s_axis_data_tready) begin
                if (last_byte) state_d = S_DONE;
                else           idx_d   = idx_q + LEN_W'(1);
            end
            S_R_CMDW: if (s_axis_cmd_ready) state_d = S_R_ADDR;
            S_R_ADDR: if (s_axis_data_tready) state_d = S_R_CMDR;
            S_R_CMDR: if (s_axis_cmd_ready) state_d = S_R_WAIT;
            S_R_WAIT: if (m_axis_data_tvalid && rd_tready) begin
                if (last_byte) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + LEN_W'(1);
                    state_d = S_R_CMDR;
                end
            end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        if (timeout) begin
            state_d = S_IDLE;
            cmd_v   = 1'b0;
            dat_v   = 1'b0;
            wr_rdy  = 1'b0;
            rd_v    = 1'b0;
            m_rdy   = 1'b0;
        end

        if ((state_q == S_IDLE) || hs || timeout || (TIMEOUT_CYCLES == 0)) wdog_d = '0;
        else                                                              wdog_d = wdog_q + WD_W'(1);

        cmd_ready                 = (state_q == S_IDLE);
        busy                      = (state_q != S_IDLE);
        done                      = (state_q == S_DONE);
        timeout_err               = timeout;
        s_axis_cmd_valid          = cmd_v;
        s_axis_cmd_address        = cmd_v ? {4'b1010, DEV_SEL | page} : 7'h00;
        s_axis_cmd_start          = cmd_v & c_start;
        s_axis_cmd_read           = cmd_v & c_read;
        s_axis_cmd_write          = cmd_v & c_write;
        s_axis_cmd_write_multiple = cmd_v & c_wm;
        s_axis_cmd_stop           = cmd_v & c_stop;
        s_axis_data_tvalid        = dat_v;
        s_axis_data_tdata         = dat_v ? dat_b : 8'h00;
        s_axis_data_tlast         = dat_v & dat_l;
        wr_tready                 = wr_rdy;
        rd_tvalid                 = rd_v;
        rd_tdata                  = rd_v ? rd_b : 8'h00;
        rd_tlast                  = rd_v & rd_l;
        m_axis_data_tready        = m_rdy;
    end
endmodule
